rgbled_rx: RTL and testbench



---
 rtl/rgbled_pkg.sv | 12 +
 rtl/sync_2ff.sv | 18 +
 rtl/rgbled_rx.sv | 115 +++++++++++
 tb/tb_rgbled_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbled_pkg.sv
// rgbled_pkg: receiver state encoding and default WS2812 timing shared with the chain driver
package rgbled_pkg;
  typedef enum logic [1:0] {GAP, IDLE, HIGH, LOW} rx_state_e;
  localparam int T0H = 20;
  localparam int T1H = 40;
  localparam int T_THRESH = 30;
  localparam int T_MAX_HIGH = 60;
  localparam int T_RESET = 2500;
  function automatic int frame_bits(input int num_leds, input int bits);
    return num_leds * bits;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk)
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  assign q = s2_q;
endmodule

// File: rtl/rgbled_rx.sv
// rgbled_rx: WS2812-style single-wire stream decoder delivering whole frames after the latch gap
module rgbled_rx #(
  parameter int NUM_LEDS   = 3,
  parameter int BITS       = 24,
  parameter int T_THRESH   = rgbled_pkg::T_THRESH,
  parameter int T_MAX_HIGH = rgbled_pkg::T_MAX_HIGH,
  parameter int T_RESET    = rgbled_pkg::T_RESET
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din,
  output logic [NUM_LEDS*BITS-1:0] data,
  output logic                     data_vld,
  output logic                     frame_err,
  output logic                     busy
);
  import rgbled_pkg::*;
  localparam int FB = frame_bits(NUM_LEDS, BITS);
  localparam int HW = $clog2(T_MAX_HIGH + 3);
  localparam int LW = $clog2(T_RESET + 2);
  localparam int BW = $clog2(FB + 3);
  localparam logic [HW-1:0] H_SAT = HW'(T_MAX_HIGH + 1);
  localparam logic [HW-1:0] H_MAX = HW'(T_MAX_HIGH);
  localparam logic [HW-1:0] H_THR = HW'(T_THRESH);
  localparam logic [LW-1:0] L_END = LW'(T_RESET);
  localparam logic [BW-1:0] B_FB  = BW'(FB);
  localparam logic [BW-1:0] B_SAT = BW'(FB + 1);
  rx_state_e state_q, state_d;
  logic ds, ds_q, rise, fall;
  logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [FB-1:0] shift_q, shift_d, data_q, data_d;
  logic vld_q, vld_d, err_q, err_d;
  sync_2ff u_sync (.clk(clk), .rst(reset), .d(din), .q(ds));
  assign rise = ds & ~ds_q;
  assign fall = ~ds & ds_q;
  assign hcnt_inc = hcnt_q == H_SAT ? hcnt_q : hcnt_q + 1'b1;
  assign lcnt_inc = lcnt_q == L_END ? lcnt_q : lcnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    bcnt_d = bcnt_q;
    shift_d = shift_q;
    data_d = data_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      GAP: begin
        lcnt_d = ds ? '0 : lcnt_inc;
        state_d = (!ds && lcnt_inc == L_END) ? IDLE : GAP;
      end
      IDLE: if (rise) begin
        bcnt_d = '0;
        hcnt_d = '0;
        state_d = HIGH;
      end
      HIGH: begin
        hcnt_d = hcnt_inc;
        if (hcnt_inc > H_MAX) begin
          err_d = 1'b1;
          lcnt_d = '0;
          state_d = GAP;
        end else if (fall) begin
          shift_d = bcnt_q < B_FB ? {shift_q[FB-2:0], hcnt_inc >= H_THR} : shift_q;
          bcnt_d = bcnt_q == B_SAT ? bcnt_q : bcnt_q + 1'b1;
          lcnt_d = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        lcnt_d = lcnt_inc;
        if (lcnt_inc == L_END) begin
          vld_d = bcnt_q == B_FB;
          err_d = bcnt_q != B_FB;
          data_d = bcnt_q == B_FB ? shift_q : data_q;
          bcnt_d = '0;
          hcnt_d = '0;
          state_d = rise ? HIGH : IDLE;
        end else if (rise) begin
          hcnt_d = '0;
          state_d = HIGH;
        end
      end
      default: state_d = GAP;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= GAP;
      ds_q <= 1'b0;
      hcnt_q <= '0;
      lcnt_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ds_q <= ds;
      hcnt_q <= hcnt_d;
      lcnt_q <= lcnt_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  assign data = data_q;
  assign data_vld = vld_q;
  assign frame_err = err_q;
  assign busy = state_q == HIGH || state_q == LOW;
endmodule

// File: tb/tb_rgbled_rx.sv
// tb_rgbled_rx: scoreboard bench for rgbled_rx with a small 2x8-bit frame
module tb_rgbled_rx;
  localparam int NL = 2, BT = 8, TT = 6, TM = 16, TR = 40;
  typedef struct {logic vld; logic err; logic [15:0] data; int cyc;} ev_t;
  logic clk = 1'b0, reset = 1'b1, din = 1'b0;
  logic [15:0] data;
  logic data_vld, frame_err, busy;
  int cyc = 0, checks = 0, fails = 0, last_fall = 0, last_rise = 0;
  ev_t exp_q[$], obs_q[$];
  rgbled_rx #(.NUM_LEDS(NL), .BITS(BT), .T_THRESH(TT), .T_MAX_HIGH(TM), .T_RESET(TR)) dut (
    .clk(clk), .reset(reset), .din(din), .data(data),
    .data_vld(data_vld), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (data_vld || frame_err) obs_q.push_back('{data_vld, frame_err, data, cyc});
  end
  task automatic hold(input logic v, input int n);
    if (v && !din) last_rise = cyc + 1;
    if (!v && din) last_fall = cyc + 1;
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bit(input logic b);
    hold(1'b1, b ? 9 : 3);
    hold(1'b0, b ? 6 : 12);
  endtask
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    din = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks += 2;
    if (data !== 16'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: data=%h busy=%b, want 0000/0", data, busy);
    end
    if (data_vld !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: vld=%b err=%b, want 0/0", data_vld, frame_err);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || data !== 16'h0) begin
      fails++;
      $display("FAIL reset_release: busy=%b data=%h, want 0/0000", busy, data);
    end
    obs_q.delete();
  endtask
  task automatic test_good_frame;
    ev_t o, e;
    hold(1'b0, 50);
    exp_q.push_back('{1'b1, 1'b0, 16'hA53C, 0});
    send_bits(32'hA5, 8);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL good_busy: busy=%b, want 1", busy);
    end
    send_bits(32'h3C, 8);
    hold(1'b0, 45);
    checks++;
    if (obs_q.size() != 1) begin
      fails++;
      $display("FAIL good_count: strobes=%0d, want 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks += 2;
      if (o.vld !== e.vld || o.err !== e.err || o.data !== e.data) begin
        fails++;
        $display("FAIL good_frame: vld=%b err=%b data=%h, want %b/%b/%h", o.vld, o.err, o.data, e.vld, e.err, e.data);
      end
      if (o.cyc - last_fall != TR + 2) begin
        fails++;
        $display("FAIL good_latency: %0d cycles after fall, want %0d", o.cyc - last_fall, TR + 2);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL good_idle_busy: busy=%b, want 0", busy);
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_short_frame;
    ev_t o, e;
    exp_q.push_back('{1'b0, 1'b1, 16'hA53C, 0});
    send_bits(32'h1234, 15);
    hold(1'b0, 45);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL short_count: strobes=%0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.vld !== e.vld || o.err !== e.err || o.data !== e.data) begin
        fails++;
        $display("FAIL short_frame: vld=%b err=%b data=%h, want %b/%b/%h", o.vld, o.err, o.data, e.vld, e.err, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_overrun;
    ev_t o, e;
    exp_q.push_back('{1'b0, 1'b1, 16'hA53C, 0});
    send_bits(32'h1B3C5, 17);
    hold(1'b0, 45);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL overrun_count: strobes=%0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.vld !== e.vld || o.err !== e.err || o.data !== e.data) begin
        fails++;
        $display("FAIL overrun: vld=%b err=%b data=%h, want %b/%b/%h", o.vld, o.err, o.data, e.vld, e.err, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_stuck_high;
    ev_t o, e;
    int stuck_rise;
    exp_q.push_back('{1'b0, 1'b1, 16'hA53C, 0});
    exp_q.push_back('{1'b1, 1'b0, 16'hFF00, 0});
    send_bits(32'h15, 5);
    hold(1'b1, 20);
    stuck_rise = last_rise;
    hold(1'b0, 45);
    send_bits(32'hFF00, 16);
    hold(1'b0, 45);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL stuck_count: strobes=%0d, want %0d", obs_q.size(), exp_q.size());
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].cyc - stuck_rise != TM + 3) begin
        fails++;
        $display("FAIL stuck_latency: err %0d cycles after rise, want %0d", obs_q[0].cyc - stuck_rise, TM + 3);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.vld !== e.vld || o.err !== e.err || o.data !== e.data) begin
        fails++;
        $display("FAIL stuck_high: vld=%b err=%b data=%h, want %b/%b/%h", o.vld, o.err, o.data, e.vld, e.err, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_boundary;
    ev_t o, e;
    int hi[5] = '{5, 7, 3, 6, 16};
    int lo[5] = '{12, 39, 12, 9, 12};
    exp_q.push_back('{1'b1, 1'b0, 16'h5A3C, 0});
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, hi[i]);
      hold(1'b0, lo[i]);
    end
    send_bits(32'h5A3C, 11);
    hold(1'b0, 45);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL boundary_count: strobes=%0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.vld !== e.vld || o.err !== e.err || o.data !== e.data) begin
        fails++;
        $display("FAIL boundary: vld=%b err=%b data=%h, want %b/%b/%h", o.vld, o.err, o.data, e.vld, e.err, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_reset_mid_frame;
    ev_t o, e;
    send_bits(32'h12, 8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data !== 16'h0 || data_vld !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: data=%h vld=%b err=%b busy=%b, want 0000/0/0/0", data, data_vld, frame_err, busy);
    end
    reset = 1'b0;
    hold(1'b0, 5);
    send_bits(32'h1234, 16);
    hold(1'b0, 45);
    checks++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL reset_no_gap: strobes=%0d, want 0", obs_q.size());
    end
    obs_q.delete();
    exp_q.push_back('{1'b1, 1'b0, 16'h1234, 0});
    send_bits(32'h1234, 16);
    hold(1'b0, 45);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL reset_frame_count: strobes=%0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.vld !== e.vld || o.err !== e.err || o.data !== e.data) begin
        fails++;
        $display("FAIL reset_frame: vld=%b err=%b data=%h, want %b/%b/%h", o.vld, o.err, o.data, e.vld, e.err, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_good_frame;
    test_short_frame;
    test_overrun;
    test_stuck_high;
    test_boundary;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
